// File: rtl/dog_anim_ctl.sv
// dog_anim_ctl: dog sprite sequencer for the Duck Hunt draw pipeline.
// Plays the intro (walk, sniff, jump, dive into grass), then a hit or miss
// reaction (pop-up, hold, sink) for each round result from the game FSM.
// Ports:
//   clk, rst_n      pixel clock, asynchronous active-low reset
//   game_enable     level; 1 starts the intro from IDLE, 0 aborts to IDLE
//   round_valid     one-cycle pulse; round_hit/round_x qualified by it
//   dog_xpos/ypos   integer sprite position (px)
//   photo_index     sprite frame select
//   dog_visible     sprite enable
//   busy            high outside IDLE and HIDDEN
//   seq_done        one-cycle pulse when the intro or a reaction ends
module dog_anim_ctl #(
  parameter int unsigned FRAC        = 24,
  parameter int unsigned X_START     = 1024,
  parameter int unsigned Y_GROUND    = 515,
  parameter int unsigned X_SPOT      = 650,
  parameter int unsigned Y_APEX      = 390,
  parameter int unsigned Y_HIDE      = 600,
  parameter int unsigned Y_SHOW      = 450,
  parameter int unsigned WALK_V      = 26,
  parameter int unsigned JUMP_VX     = 20,
  parameter int unsigned JUMP_VY     = 70,
  parameter int unsigned FALL_VY     = 50,
  parameter int unsigned POP_VY      = 40,
  parameter int unsigned WALK_FRAMES = 6,
  parameter int unsigned FRAME_DIV   = 8388608,
  parameter int unsigned SPOT_CYCLES = 2000000,
  parameter int unsigned SHOW_CYCLES = 40000000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        game_enable,
  input  logic        round_valid,
  input  logic        round_hit,
  input  logic [11:0] round_x,
  output logic [11:0] dog_xpos,
  output logic [11:0] dog_ypos,
  output logic [3:0]  photo_index,
  output logic        dog_visible,
  output logic        busy,
  output logic        seq_done
);

  localparam int unsigned POS_W = FRAC + 12;
  localparam int unsigned CNT_W = 32;

  localparam logic [POS_W-1:0] X_START_FX  = POS_W'(X_START) << FRAC;
  localparam logic [POS_W-1:0] Y_GROUND_FX = POS_W'(Y_GROUND) << FRAC;
  localparam logic [POS_W-1:0] X_SPOT_FX   = POS_W'(X_SPOT) << FRAC;
  localparam logic [POS_W-1:0] Y_APEX_FX   = POS_W'(Y_APEX) << FRAC;
  localparam logic [POS_W-1:0] Y_HIDE_FX   = POS_W'(Y_HIDE) << FRAC;
  localparam logic [POS_W-1:0] Y_SHOW_FX   = POS_W'(Y_SHOW) << FRAC;
  localparam logic [POS_W-1:0] ZERO_FX     = '0;

  localparam logic [POS_W-1:0] WALK_V_FX  = POS_W'(WALK_V);
  localparam logic [POS_W-1:0] JUMP_VX_FX = POS_W'(JUMP_VX);
  localparam logic [POS_W-1:0] JUMP_VY_FX = POS_W'(JUMP_VY);
  localparam logic [POS_W-1:0] FALL_VY_FX = POS_W'(FALL_VY);
  localparam logic [POS_W-1:0] POP_VY_FX  = POS_W'(POP_VY);

  localparam logic [3:0] PH_WALK_LAST = 4'(WALK_FRAMES - 1);
  localparam logic [3:0] PH_SPOT      = 4'(WALK_FRAMES);
  localparam logic [3:0] PH_JUMP      = 4'(WALK_FRAMES + 1);
  localparam logic [3:0] PH_FALL      = 4'(WALK_FRAMES + 2);
  localparam logic [3:0] PH_HIT       = 4'(WALK_FRAMES + 3);
  localparam logic [3:0] PH_LAUGH0    = 4'(WALK_FRAMES + 4);
  localparam logic [3:0] PH_LAUGH1    = 4'(WALK_FRAMES + 5);

  localparam logic [CNT_W-1:0] DIV_LAST  = CNT_W'(FRAME_DIV - 1);
  localparam logic [CNT_W-1:0] SPOT_LAST = CNT_W'(SPOT_CYCLES - 1);
  localparam logic [CNT_W-1:0] SHOW_LAST = CNT_W'(SHOW_CYCLES - 1);

  typedef enum logic [3:0] {
    S_IDLE, S_WALK, S_SPOT, S_JUMP, S_FALL, S_HIDDEN, S_POP, S_SHOW, S_SINK
  } state_e;

  state_e            state_q, state_d;
  logic [POS_W-1:0]  x_q, x_d, y_q, y_d;
  logic [3:0]        photo_q, photo_d;
  logic              vis_q, vis_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              hit_q, hit_d;
  logic [CNT_W-1:0]  div_q, div_d, cnt_q, cnt_d;
  logic              div_tick;

  // Decrement toward tgt; a step that would pass tgt lands exactly on it.
  function automatic logic [POS_W-1:0] step_dn(input logic [POS_W-1:0] p,
                                               input logic [POS_W-1:0] step,
                                               input logic [POS_W-1:0] tgt);
    logic [POS_W:0] lim;
    lim = {1'b0, tgt} + {1'b0, step};
    if ({1'b0, p} < lim) return tgt;
    return p - step;
  endfunction

  // Increment toward tgt with the same exact-landing clamp.
  function automatic logic [POS_W-1:0] step_up(input logic [POS_W-1:0] p,
                                               input logic [POS_W-1:0] step,
                                               input logic [POS_W-1:0] tgt);
    logic [POS_W:0] sum;
    sum = {1'b0, p} + {1'b0, step};
    if (sum > {1'b0, tgt}) return tgt;
    return sum[POS_W-1:0];
  endfunction

  // Next-state, position and output computation.
  always_comb begin
    state_d  = state_q;
    x_d      = x_q;
    y_d      = y_q;
    photo_d  = photo_q;
    vis_d    = vis_q;
    hit_d    = hit_q;
    done_d   = 1'b0;
    div_tick = (div_q == DIV_LAST);

    unique case (state_q)
      S_IDLE: begin
        if (game_enable) state_d = S_WALK;
      end
      S_WALK: begin
        if (x_q <= X_SPOT_FX) begin
          state_d = S_SPOT;
          photo_d = PH_SPOT;
        end else begin
          x_d = step_dn(x_q, WALK_V_FX, X_SPOT_FX);
          if (div_tick) photo_d = (photo_q == PH_WALK_LAST) ? 4'd0 : 4'(photo_q + 4'd1);
        end
      end
      S_SPOT: begin
        if (cnt_q == SPOT_LAST) begin
          state_d = S_JUMP;
          photo_d = PH_JUMP;
        end
      end
      S_JUMP: begin
        if (y_q <= Y_APEX_FX) begin
          state_d = S_FALL;
          photo_d = PH_FALL;
        end else begin
          x_d = step_dn(x_q, JUMP_VX_FX, ZERO_FX);
          y_d = step_dn(y_q, JUMP_VY_FX, Y_APEX_FX);
        end
      end
      S_FALL: begin
        if (y_q >= Y_HIDE_FX) begin
          state_d = S_HIDDEN;
          y_d     = Y_HIDE_FX;
          vis_d   = 1'b0;
          done_d  = 1'b1;
        end else begin
          x_d = step_dn(x_q, JUMP_VX_FX, ZERO_FX);
          y_d = step_up(y_q, FALL_VY_FX, Y_HIDE_FX);
        end
      end
      S_HIDDEN: begin
        y_d = Y_HIDE_FX;
        if (round_valid) begin
          state_d = S_POP;
          hit_d   = round_hit;
          x_d     = POS_W'(round_x) << FRAC;
          photo_d = round_hit ? PH_HIT : PH_LAUGH0;
          vis_d   = 1'b1;
        end
      end
      S_POP: begin
        if (y_q <= Y_SHOW_FX) state_d = S_SHOW;
        else                  y_d     = step_dn(y_q, POP_VY_FX, Y_SHOW_FX);
      end
      S_SHOW: begin
        if (cnt_q == SHOW_LAST) begin
          state_d = S_SINK;
        end else if (!hit_q && div_tick) begin
          photo_d = (photo_q == PH_LAUGH0) ? PH_LAUGH1 : PH_LAUGH0;
        end
      end
      S_SINK: begin
        if (y_q >= Y_HIDE_FX) begin
          state_d = S_HIDDEN;
          vis_d   = 1'b0;
          done_d  = 1'b1;
        end else begin
          y_d = step_up(y_q, POP_VY_FX, Y_HIDE_FX);
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Dropping game_enable overrides every other event.
    if (!game_enable) begin
      state_d = S_IDLE;
      x_d     = X_START_FX;
      y_d     = Y_GROUND_FX;
      photo_d = 4'd0;
      vis_d   = 1'b1;
      hit_d   = 1'b0;
      done_d  = 1'b0;
    end

    // Divider and hold counter restart on each state entry.
    if (state_d != state_q || state_d == S_IDLE) begin
      div_d = '0;
      cnt_d = '0;
    end else begin
      div_d = div_tick ? '0 : CNT_W'(div_q + 1'b1);
      cnt_d = CNT_W'(cnt_q + 1'b1);
    end

    busy_d = !(state_d == S_IDLE || state_d == S_HIDDEN);
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      x_q     <= X_START_FX;
      y_q     <= Y_GROUND_FX;
      photo_q <= 4'd0;
      vis_q   <= 1'b1;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      hit_q   <= 1'b0;
      div_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      x_q     <= x_d;
      y_q     <= y_d;
      photo_q <= photo_d;
      vis_q   <= vis_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      hit_q   <= hit_d;
      div_q   <= div_d;
      cnt_q   <= cnt_d;
    end
  end

  assign dog_xpos    = x_q[FRAC +: 12];
  assign dog_ypos    = y_q[FRAC +: 12];
  assign photo_index = photo_q;
  assign dog_visible = vis_q;
  assign busy        = busy_q;
  assign seq_done    = done_q;

endmodule
